// File: rtl/karatsuba2_seq_ctrl_pkg.sv
// Shared widths and controller state encoding for the sequenced
// two-way Karatsuba carry-less multiplier.
package karatsuba2_seq_ctrl_pkg;

  localparam int W  = 163;
  localparam int LO = W / 2;
  localparam int HI = W - LO;
  localparam int PW = 2 * HI - 1;
  localparam int CW = 2 * W;

  typedef enum logic [2:0] {
    IDLE,
    MUL_HH,
    MUL_LL,
    MUL_MID,
    COMBINE,
    DONE
  } state_t;

endpackage

// File: rtl/karatsuba2_seq_ctrl_gf2_serial_mul.sv
// Bit-serial GF(2)[x] multiplier: scans one bit of x per cycle and folds
// the shifted y into the accumulator; done pulses once p is complete.
module gf2_serial_mul #(
  parameter int K = 82
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K-1:0]   x,
  input  logic [K-1:0]   y,
  output logic           done,
  output logic [2*K-2:0] p
);

  localparam int CNT_W = $clog2(K);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  logic [K-1:0]     xr;
  logic [K-1:0]     yr;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [2*K-2:0]   acc;

  function automatic logic [2*K-2:0] term(input logic sel, input logic [K-1:0] v,
                                           input logic [CNT_W-1:0] sh);
    logic [2*K-2:0] ext;
    ext = {{(K-1){1'b0}}, v};
    return sel ? (ext << sh) : '0;
  endfunction

  // Bit 0 is folded in on the start edge so a full product takes K edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      acc     <= term(x[0], y, '0);
      cnt     <= CNT_W'(1);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      acc <= acc ^ term(xr[cnt], yr, cnt);
      if (cnt == LAST) begin
        running <= 1'b0;
        cnt     <= '0;
        done    <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      xr <= x;
      yr <= y;
    end
  end

  assign p = acc;

endmodule

// File: rtl/karatsuba2_seq_ctrl.sv
// Sequenced Karatsuba controller: runs hh, ll and mid products through one
// shared serial multiplier, then XOR-recombines them into c.
module karatsuba2_seq_ctrl
  import karatsuba2_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] c,
  output logic          busy
);

  state_t state, state_nx;

  logic [HI-1:0] ah, al, bh, bl;
  logic          accept;
  logic          kick;
  logic          sub_start;
  logic          sub_done;
  logic [HI-1:0] sub_x, sub_y;
  logic [PW-1:0] sub_p;
  logic [PW-1:0] p_hh, p_ll, p_mid;

  function automatic logic [CW-1:0] recombine(input logic [PW-1:0] hh,
                                              input logic [PW-1:0] ll,
                                              input logic [PW-1:0] mid);
    logic [CW-1:0] eh, el, em;
    eh = CW'(hh);
    el = CW'(ll);
    em = CW'(mid ^ hh ^ ll);
    return (eh << (2 * LO)) ^ (em << LO) ^ el;
  endfunction

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = MUL_HH;
      MUL_HH:  if (sub_done)  state_nx = MUL_LL;
      MUL_LL:  if (sub_done)  state_nx = MUL_MID;
      MUL_MID: if (sub_done)  state_nx = COMBINE;
      COMBINE:                state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // The first product is kicked one cycle after acceptance from the latched
  // operands; later products start on the same edge the previous one is stored.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    sub_start = 1'b0;
    sub_x     = ah;
    sub_y     = bh;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      MUL_HH: begin
        sub_start = kick | sub_done;
        if (!kick) begin
          sub_x = al;
          sub_y = bl;
        end
      end
      MUL_LL: begin
        sub_start = sub_done;
        sub_x     = ah ^ al;
        sub_y     = bh ^ bl;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ah <= a[W-1:LO];
      al <= {{(HI-LO){1'b0}}, a[LO-1:0]};
      bh <= b[W-1:LO];
      bl <= {{(HI-LO){1'b0}}, b[LO-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kick  <= 1'b0;
      p_hh  <= '0;
      p_ll  <= '0;
      p_mid <= '0;
      c     <= '0;
    end else begin
      kick <= accept;
      if (sub_done) begin
        case (state)
          MUL_HH:  p_hh  <= sub_p;
          MUL_LL:  p_ll  <= sub_p;
          MUL_MID: p_mid <= sub_p;
          default: ;
        endcase
      end
      if (state == COMBINE) c <= recombine(p_hh, p_ll, p_mid);
    end
  end

  gf2_serial_mul #(
    .K (HI)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (sub_start),
    .x     (sub_x),
    .y     (sub_y),
    .done  (sub_done),
    .p     (sub_p)
  );

endmodule
